mem_read_sequencer: RTL and testbench

Upstream sequencer for `mem_read_buffer_avalon_interface`. Given a start address and a word count, it issues sequential 32-bit word reads through that block's `read_addr`/`read`/`waitrequest`/`oData` port. Returned words go into an internal show-ahead FIFO, which the block presents to the ISP pipeline as a valid/ready stream. A busy flag and a one-cycle done pulse mark each transfer.

---
 rtl/mem_read_sequencer.sv | 171 +++++++++++++++++
 tb/tb_mem_read_sequencer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_read_sequencer.sv
// Sequential 32-bit word reader feeding a show-ahead FIFO exposed as a valid/ready stream.
// Optional abort support is compiled in with `define MEM_READ_SEQ_ABORT_EN.
module mem_read_sequencer #(
  parameter int DATAWIDTH      = 32,
  parameter int FIFODEPTH      = 16,
  parameter int FIFODEPTH_LOG2 = 4,
  parameter int LENGTHWIDTH    = 24
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [31:0]            start_addr,
  input  logic [LENGTHWIDTH-1:0] length,
  output logic                   busy,
  output logic                   done,
  output logic [31:0]            read_addr,
  output logic                   read,
  input  logic                   waitrequest,
  input  logic [31:0]            iData,
  output logic [DATAWIDTH-1:0]   stream_data,
  output logic                   stream_valid,
  input  logic                   stream_ready
`ifdef MEM_READ_SEQ_ABORT_EN
  ,
  input  logic                   abort,
  output logic                   aborted
`endif
);

  localparam int CW = FIFODEPTH_LOG2 + 1;
  localparam logic [CW-1:0]             DEPTH_CNT = CW'(FIFODEPTH);
  localparam logic [CW-1:0]             CNT_ONE   = CW'(1);
  localparam logic [FIFODEPTH_LOG2-1:0] PTR_ONE   = FIFODEPTH_LOG2'(1);
  localparam logic [LENGTHWIDTH-1:0]    LEN_ONE   = LENGTHWIDTH'(1);
  localparam logic [31:0]               ADDR_STEP = 32'd4;

`ifdef MEM_READ_SEQ_ABORT_EN
  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_ABORT} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;
`endif

  state_t                    state;
  logic [LENGTHWIDTH-1:0]    remaining;
  logic [CW-1:0]             count;
  logic [CW-1:0]             count_next;
  logic [FIFODEPTH_LOG2-1:0] wr_ptr;
  logic [FIFODEPTH_LOG2-1:0] rd_ptr;
  logic [DATAWIDTH-1:0]      mem [FIFODEPTH];
  logic                      accept;
  logic                      push;
  logic                      pop;

  assign accept       = read && !waitrequest;
  assign stream_valid = (count != '0);
  assign pop          = stream_valid && stream_ready;
  assign stream_data  = stream_valid ? mem[rd_ptr] : '0;

  always_comb begin
    push = accept && (state == S_READ);
`ifdef MEM_READ_SEQ_ABORT_EN
    if (abort) push = 1'b0;
`endif
    count_next = count;
    if (push && !pop)
      count_next = count + CNT_ONE;
    else if (!push && pop)
      count_next = count - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= iData;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      read      <= 1'b0;
      read_addr <= '0;
      remaining <= '0;
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
`ifdef MEM_READ_SEQ_ABORT_EN
      aborted   <= 1'b0;
`endif
    end else begin
      done  <= 1'b0;
`ifdef MEM_READ_SEQ_ABORT_EN
      aborted <= 1'b0;
`endif
      count <= count_next;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;

      case (state)
        S_IDLE: begin
          if (start) begin
            if (length != '0) begin
              state     <= S_READ;
              busy      <= 1'b1;
              read      <= 1'b1;
              read_addr <= start_addr & ~32'h3;
              remaining <= length;
            end else begin
              done <= 1'b1;
            end
          end
        end

        S_READ: begin
`ifdef MEM_READ_SEQ_ABORT_EN
          // A stalled request must stay asserted until accepted; its word is dropped.
          if (abort) begin
            state  <= S_ABORT;
            read   <= read && waitrequest;
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
          end else
`endif
          if (accept) begin
            read_addr <= read_addr + ADDR_STEP;
            remaining <= remaining - LEN_ONE;
            if (remaining == LEN_ONE) begin
              state <= S_DRAIN;
              read  <= 1'b0;
            end else begin
              read <= (count_next < DEPTH_CNT);
            end
          end else begin
            read <= (count_next < DEPTH_CNT);
          end
        end

        S_DRAIN: begin
`ifdef MEM_READ_SEQ_ABORT_EN
          if (abort) begin
            state  <= S_ABORT;
            read   <= 1'b0;
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
          end else
`endif
          if (count_next == '0) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end

`ifdef MEM_READ_SEQ_ABORT_EN
        S_ABORT: begin
          if (!read || !waitrequest) begin
            read    <= 1'b0;
            aborted <= 1'b1;
            busy    <= 1'b0;
            state   <= S_IDLE;
          end
        end
`endif

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_read_sequencer.sv
// Self-checking bench for mem_read_sequencer: directed cases plus randomized transfers
// checked against a transaction-level model (address/data queue and occupancy arithmetic).
module tb_mem_read_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] start_addr;
  logic [23:0] length;
  logic        busy;
  logic        done;
  logic [31:0] read_addr;
  logic        read;
  logic        waitrequest;
  logic [31:0] iData;
  logic [31:0] stream_data;
  logic        stream_valid;
  logic        stream_ready;
`ifdef MEM_READ_SEQ_ABORT_EN
  logic        abort = 1'b0;
  logic        aborted;
`endif

  mem_read_sequencer #(
    .DATAWIDTH(32),
    .FIFODEPTH(16),
    .FIFODEPTH_LOG2(4),
    .LENGTHWIDTH(24)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .start_addr(start_addr),
    .length(length),
    .busy(busy),
    .done(done),
    .read_addr(read_addr),
    .read(read),
    .waitrequest(waitrequest),
    .iData(iData),
    .stream_data(stream_data),
    .stream_valid(stream_valid),
    .stream_ready(stream_ready)
`ifdef MEM_READ_SEQ_ABORT_EN
    ,
    .abort(abort),
    .aborted(aborted)
`endif
  );

  always #5 clk = ~clk;

  // Memory contents: word at byte address A is A ^ key.
  logic [31:0] key;
  assign iData = read_addr ^ key;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  // Transaction-level reference state
  bit          active   = 1'b0;
  bit          exp_done = 1'b0;
  logic [31:0] base;
  int unsigned xfer_len = 0;
  int unsigned acc      = 0;
  int unsigned popped   = 0;
  int unsigned dut_acc  = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    active   = 1'b0;
    exp_done = 1'b0;
    acc      = 0;
    popped   = 0;
    xfer_len = 0;
    exp_q.delete();
  endtask

  // One clock cycle: check outputs against the model, advance the model, clock.
  task automatic cyc();
    int unsigned occ;
    bit          exp_read;
    bit          done_next;
    occ      = acc - popped;
    exp_read = active && (acc < xfer_len) && (occ < 16);
    chk("done", done, exp_done);
    chk("busy", busy, active);
    chk("read", read, exp_read);
    chk("stream_valid", stream_valid, occ != 0);
    if (exp_read) chk("read_addr", read_addr, base + (acc << 2));
    if (read && !waitrequest) dut_acc++;
    if (exp_read && !waitrequest) acc++;
    if (occ != 0 && stream_ready) begin
      chk("stream_data", stream_data, exp_q.pop_front());
      popped++;
    end
    done_next = 1'b0;
    if (active && acc == xfer_len && acc == popped) begin
      done_next = 1'b1;
      active    = 1'b0;
    end else if (!active && start) begin
      if (length == 24'd0) begin
        done_next = 1'b1;
      end else begin
        active   = 1'b1;
        base     = start_addr & ~32'h3;
        xfer_len = length;
        acc      = 0;
        popped   = 0;
        exp_q.delete();
        for (int unsigned k = 0; k < xfer_len; k++)
          exp_q.push_back((base + (k << 2)) ^ key);
      end
    end
    @(posedge clk);
    #1;
    exp_done = done_next;
  endtask

  task automatic do_start(input logic [31:0] a, input int unsigned len);
    dut_acc    = 0;
    start      = 1'b1;
    start_addr = a;
    length     = 24'(len);
    cyc();
    start      = 1'b0;
  endtask

  task automatic run(input int max_cycles, input bit rand_mode);
    int n = 0;
    while ((active || exp_done) && n < max_cycles) begin
      if (rand_mode) begin
        waitrequest  = ($urandom_range(0, 3) == 0);
        stream_ready = ($urandom_range(0, 2) != 0);
      end
      cyc();
      n++;
    end
    chk("run_complete", {31'b0, active || exp_done}, 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_read"}, read, 0);
    chk({tag, "_read_addr"}, read_addr, 0);
    chk({tag, "_stream_valid"}, stream_valid, 0);
    chk({tag, "_stream_data"}, stream_data, 0);
  endtask

  initial begin
    reset        = 1'b0;
    start        = 1'b0;
    start_addr   = '0;
    length       = '0;
    waitrequest  = 1'b0;
    stream_ready = 1'b0;
    key          = '0;
    model_clear();

    @(posedge clk);
    #1;
    chk_reset_outputs("init_rst");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    cyc();

    // Basic transfer, memory word equals its address
    key = 32'h0;
    waitrequest  = 1'b0;
    stream_ready = 1'b1;
    do_start(32'h0000_1000, 4);
    run(50, 1'b0);
    chk("basic_reads", dut_acc, 4);

    // Backpressure: FIFO fills to 16, then reads stop
    key = 32'h00FF_0000;
    stream_ready = 1'b0;
    do_start(32'h0000_2000, 40);
    repeat (30) cyc();
    chk("fill_reads", dut_acc, 16);
    stream_ready = 1'b1;
    run(200, 1'b0);
    chk("total_reads", dut_acc, 40);

    // Five-cycle stall on the second word
    key = 32'h0BAD_0000;
    waitrequest = 1'b0;
    do_start(32'h0000_3000, 6);
    cyc();
    waitrequest = 1'b1;
    repeat (5) cyc();
    waitrequest = 1'b0;
    run(50, 1'b0);
    chk("stall_reads", dut_acc, 6);

    // Address wrap past 2^32, with low address bits set
    key = 32'h5555_0000;
    do_start(32'hFFFF_FFFB, 3);
    run(50, 1'b0);

    // Zero length: done at T+1, no reads
    do_start(32'h0000_4000, 0);
    run(5, 1'b0);
    cyc();
    chk("zero_len_reads", dut_acc, 0);

    // Randomized transfers
    for (int t = 0; t < 12; t++) begin
      key          = $urandom;
      waitrequest  = ($urandom_range(0, 1) == 1);
      stream_ready = ($urandom_range(0, 1) == 1);
      do_start($urandom, $urandom_range(1, 50));
      run(3000, 1'b1);
    end

    // Reset during an active transfer
    waitrequest  = 1'b0;
    stream_ready = 1'b0;
    key = 32'hCAFE_0000;
    do_start(32'h0000_5000, 30);
    repeat (8) cyc();
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk_reset_outputs("mid_rst");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    model_clear();
    cyc();
    stream_ready = 1'b1;
    do_start(32'h0000_6000, 5);
    run(50, 1'b0);

`ifdef MEM_READ_SEQ_ABORT_EN
    // Abort while a read is stalled
    stream_ready = 1'b0;
    waitrequest  = 1'b0;
    key = 32'h1234_0000;
    do_start(32'h0000_7000, 10);
    cyc();
    cyc();
    waitrequest = 1'b1;
    cyc();
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort_read_held", read, 1);
    chk("abort_addr_held", read_addr, 32'h0000_7008);
    chk("abort_flushed", stream_valid, 0);
    chk("abort_early", aborted, 0);
    @(posedge clk);
    #1;
    chk("abort_read_held2", read, 1);
    chk("abort_no_done0", done, 0);
    waitrequest = 1'b0;
    @(posedge clk);
    #1;
    chk("aborted_pulse", aborted, 1);
    chk("abort_no_done1", done, 0);
    chk("abort_busy", busy, 0);
    chk("abort_read_low", read, 0);
    chk("abort_empty", stream_valid, 0);
    @(posedge clk);
    #1;
    chk("aborted_once", aborted, 0);
    chk("abort_no_done2", done, 0);
    model_clear();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
